// File: rtl/shim_boot_pkg.sv
// Shared types and defaults for the shim board power-up self-test sequencer.
package shim_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int TIMEOUT_CYC_DEF = 4096;
    localparam int TO_W_DEF        = 13;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/shim_boot_test_seq_if.sv
// Request/result handshake between the self-test sequencer and the channel test engine.
interface shim_boot_test_seq_if #(
    parameter int N_CH = 16
);
    import shim_boot_pkg::*;

    localparam int CW = ch_w(N_CH);

    logic          test_req;
    logic [CW-1:0] test_ch;
    logic          test_done;
    logic          test_pass;

    modport master (
        output test_req,
        output test_ch,
        input  test_done,
        input  test_pass
    );

    modport slave (
        input  test_req,
        input  test_ch,
        output test_done,
        output test_pass
    );

endinterface

// File: rtl/shim_timeout_ctr.sv
// Loadable up-counter with a terminal-count flag; used as a per-test watchdog.
module shim_timeout_ctr #(
    parameter int W    = 13,
    parameter int TERM = 4095
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority over counting.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == W'(TERM));

endmodule

// File: rtl/shim_boot_test_seq.sv
// Power-up self-test sequencer: walks every non-skipped channel, issues one
// test request each, and records pass/fail/timeout with optional debug pauses.
module shim_boot_test_seq
    import shim_boot_pkg::*;
#(
    parameter int N_CH        = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic                   spi_clk,
    input  logic                   spi_reset,
    input  logic                   spi_en_sync,
    input  logic [N_CH-1:0]        boot_test_skip,
    input  logic [N_CH-1:0]        boot_test_debug,
    shim_boot_test_seq_if.master   eng,
    output logic                   debug_hold,
    input  logic                   debug_continue,
    output logic                   busy,
    output logic                   done,
    output logic [N_CH-1:0]        pass_mask,
    output logic [N_CH-1:0]        fail_mask,
    output logic [N_CH-1:0]        timeout_mask,
    output logic                   any_fail
);

    localparam int            CW      = ch_w(N_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [N_CH-1:0] skip_snap_q, skip_snap_d;
    logic [N_CH-1:0] debug_snap_q, debug_snap_d;
    logic [N_CH-1:0] pass_mask_q, pass_mask_d;
    logic [N_CH-1:0] fail_mask_q, fail_mask_d;
    logic [N_CH-1:0] timeout_mask_q, timeout_mask_d;
    logic            test_req_q, test_req_d;
    logic            debug_hold_q, debug_hold_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            en_prev_q;
    logic            any_fail_q;

    logic            start;
    logic            ctr_load;
    logic            ctr_en;
    logic            ctr_tc;
    logic            result_now;
    logic            advance;
    logic [N_CH-1:0] ch_sel;

    // One-hot decode of the channel under test, used to set a single mask bit.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch_sel
            assign ch_sel[gi] = (ch_q == CW'(gi));
        end
    endgenerate

    assign start = spi_en_sync & ~en_prev_q;

    shim_timeout_ctr #(
        .W    (TO_W),
        .TERM (TIMEOUT_CYC - 1)
    ) u_timeout_ctr (
        .clk        (spi_clk),
        .srst       (spi_reset),
        .load_i     (ctr_load),
        .en_i       (ctr_en),
        .load_val_i ('0),
        .tc_o       (ctr_tc)
    );

    // Next-state and next-output logic; abort beats everything, then start.
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        skip_snap_d    = skip_snap_q;
        debug_snap_d   = debug_snap_q;
        pass_mask_d    = pass_mask_q;
        fail_mask_d    = fail_mask_q;
        timeout_mask_d = timeout_mask_q;
        test_req_d     = test_req_q;
        debug_hold_d   = debug_hold_q;
        busy_d         = busy_q;
        done_d         = done_q;
        ctr_load       = 1'b0;
        ctr_en         = 1'b0;
        result_now     = 1'b0;
        advance        = 1'b0;

        if ((state_q != ST_IDLE) && !spi_en_sync) begin
            // Abort keeps the partial masks so software can inspect them.
            state_d      = ST_IDLE;
            test_req_d   = 1'b0;
            debug_hold_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            skip_snap_d    = boot_test_skip;
            debug_snap_d   = boot_test_debug;
            pass_mask_d    = '0;
            fail_mask_d    = '0;
            timeout_mask_d = '0;
            ch_d           = '0;
            state_d        = ST_SCAN;
            busy_d         = 1'b1;
            done_d         = 1'b0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (skip_snap_q[ch_q]) begin
                        advance = 1'b1;
                    end else begin
                        state_d    = ST_WAIT;
                        test_req_d = 1'b1;
                        ctr_load   = 1'b1;
                    end
                end
                ST_WAIT: begin
                    ctr_en = 1'b1;
                    // A completion on the terminal cycle counts as a real result.
                    if (eng.test_done) begin
                        test_req_d = 1'b0;
                        result_now = 1'b1;
                        if (eng.test_pass) begin
                            pass_mask_d = pass_mask_q | ch_sel;
                        end else begin
                            fail_mask_d = fail_mask_q | ch_sel;
                        end
                    end else if (ctr_tc) begin
                        test_req_d     = 1'b0;
                        result_now     = 1'b1;
                        fail_mask_d    = fail_mask_q | ch_sel;
                        timeout_mask_d = timeout_mask_q | ch_sel;
                    end
                end
                ST_HOLD: begin
                    if (debug_continue) begin
                        debug_hold_d = 1'b0;
                        advance      = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (result_now) begin
                if (debug_snap_q[ch_q]) begin
                    state_d      = ST_HOLD;
                    debug_hold_d = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end

            if (advance) begin
                if (ch_q == LAST_CH) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = ST_SCAN;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge spi_clk) begin
        if (spi_reset) begin
            state_q        <= ST_IDLE;
            ch_q           <= '0;
            skip_snap_q    <= '0;
            debug_snap_q   <= '0;
            pass_mask_q    <= '0;
            fail_mask_q    <= '0;
            timeout_mask_q <= '0;
            test_req_q     <= 1'b0;
            debug_hold_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            en_prev_q      <= 1'b0;
            any_fail_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            skip_snap_q    <= skip_snap_d;
            debug_snap_q   <= debug_snap_d;
            pass_mask_q    <= pass_mask_d;
            fail_mask_q    <= fail_mask_d;
            timeout_mask_q <= timeout_mask_d;
            test_req_q     <= test_req_d;
            debug_hold_q   <= debug_hold_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            en_prev_q      <= spi_en_sync;
            any_fail_q     <= |fail_mask_q;
        end
    end

    assign eng.test_req = test_req_q;
    assign eng.test_ch  = ch_q;
    assign debug_hold   = debug_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass_mask    = pass_mask_q;
    assign fail_mask    = fail_mask_q;
    assign timeout_mask = timeout_mask_q;
    assign any_fail     = any_fail_q;

endmodule

// File: tb/tb_shim_boot_test_seq.sv
// Scoreboard bench for shim_boot_test_seq: a run-level reference model
// predicts request order/timing and final masks; a monitor checks them.
module tb_shim_boot_test_seq;

    localparam int N  = 16;
    localparam int TO = 4096;

    logic          clk = 1'b0;
    logic          spi_reset;
    logic          en;
    logic [N-1:0]  skip_in;
    logic [N-1:0]  dbg_in;
    logic          cont;
    logic          debug_hold;
    logic          busy;
    logic          done;
    logic [N-1:0]  pass_mask;
    logic [N-1:0]  fail_mask;
    logic [N-1:0]  timeout_mask;
    logic          any_fail;

    shim_boot_test_seq_if #(.N_CH(N)) eng_if ();

    shim_boot_test_seq #(.N_CH(N), .TIMEOUT_CYC(TO), .TO_W(13)) dut (
        .spi_clk         (clk),
        .spi_reset       (spi_reset),
        .spi_en_sync     (en),
        .boot_test_skip  (skip_in),
        .boot_test_debug (dbg_in),
        .eng             (eng_if),
        .debug_hold      (debug_hold),
        .debug_continue  (cont),
        .busy            (busy),
        .done            (done),
        .pass_mask       (pass_mask),
        .fail_mask       (fail_mask),
        .timeout_mask    (timeout_mask),
        .any_fail        (any_fail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model state: engine behaviour per channel and run snapshot.
    int           lat [N];   // 0 = engine never answers
    bit           pres [N];
    logic [N-1:0] skip_m, dbg_m;
    logic [N-1:0] e_pass, e_fail, e_to;

    typedef struct { int ch; int cyc; int w; } req_t;
    typedef struct { int cyc; logic [N-1:0] p; logic [N-1:0] f; logic [N-1:0] t; } done_t;
    req_t  exp_req_q [$];
    done_t exp_done_q [$];

    // From the cycle a channel scan begins: a skipped channel costs one cycle,
    // a tested one costs one scan cycle plus its wait; stop at a debug channel.
    task automatic plan(input int first_ch, input int s_cyc, output int hold_cyc);
        int    t;
        int    w;
        bit    stop;
        req_t  r;
        done_t d;
        t = s_cyc; hold_cyc = -1; stop = 0;
        for (int c = first_ch; c < N && !stop; c++) begin
            if (skip_m[c]) begin
                t += 1;
            end else begin
                w = (lat[c] == 0) ? TO : lat[c];
                r.ch = c; r.cyc = t + 1; r.w = w;
                exp_req_q.push_back(r);
                t += 1 + w;
                if (lat[c] == 0) begin e_fail[c] = 1'b1; e_to[c] = 1'b1; end
                else if (pres[c]) e_pass[c] = 1'b1;
                else e_fail[c] = 1'b1;
                if (dbg_m[c]) begin hold_cyc = t; stop = 1; end
            end
        end
        if (!stop) begin
            d.cyc = t; d.p = e_pass; d.f = e_fail; d.t = e_to;
            exp_done_q.push_back(d);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [N-1:0] skip, input logic [N-1:0] dbg, output int hold_cyc);
        skip_m = skip; dbg_m = dbg;
        skip_in = skip; dbg_in = dbg;
        e_pass = '0; e_fail = '0; e_to = '0;
        en = 1'b1;
        plan(0, cyc + 1, hold_cyc);
    endtask

    task automatic finish_run(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin step(1); k++; end
        if (!done) chk("run_done_timeout", done, 1'b1);
        step(3);
        en = 1'b0;
        step(2);
    endtask

    task automatic run(input logic [N-1:0] skip, input logic [N-1:0] dbg);
        int h;
        start_run(skip, dbg, h);
        finish_run(9000);
    endtask

    // Behavioural test engine: answers lat[ch] cycles after the request rises.
    initial begin
        int ecnt;
        ecnt = 0;
        eng_if.test_done = 1'b0;
        eng_if.test_pass = 1'b0;
        forever begin
            @(posedge clk); #1;
            eng_if.test_done = 1'b0;
            eng_if.test_pass = 1'($urandom);
            if (eng_if.test_req) begin
                ecnt++;
                if (lat[eng_if.test_ch] != 0 && ecnt == lat[eng_if.test_ch]) begin
                    eng_if.test_done = 1'b1;
                    eng_if.test_pass = pres[eng_if.test_ch];
                end
            end else begin
                ecnt = 0;
            end
        end
    end

    // Monitor: pops expectations when the DUT raises a request or finishes a run.
    initial begin
        bit    req_p, done_p, af_pend;
        logic  af_exp;
        int    rstart, cur_w;
        req_t  r;
        done_t d;
        req_p = 0; done_p = 0; af_pend = 0; af_exp = 0; rstart = 0; cur_w = 0;
        forever begin
            @(negedge clk);
            if (af_pend) begin
                chk("any_fail", any_fail, af_exp);
                af_pend = 0;
            end
            if (eng_if.test_req && !req_p) begin
                if (exp_req_q.size() == 0) begin
                    chk("req_unexpected", eng_if.test_req, 1'b0);
                end else begin
                    r = exp_req_q.pop_front();
                    chk("req_ch", 32'(eng_if.test_ch), r.ch);
                    chk("req_cycle", cyc, r.cyc);
                    cur_w  = r.w;
                    rstart = cyc;
                end
            end
            // A request cut short by abort/reset has busy and done both low.
            if (!eng_if.test_req && req_p && (busy || done))
                chk("req_width", cyc - rstart, cur_w);
            if (done && !done_p) begin
                if (exp_done_q.size() == 0) begin
                    chk("done_unexpected", done, 1'b0);
                end else begin
                    d = exp_done_q.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("pass_mask", pass_mask, d.p);
                    chk("fail_mask", fail_mask, d.f);
                    chk("timeout_mask", timeout_mask, d.t);
                    chk("busy_at_done", busy, 1'b0);
                    af_pend = 1;
                    af_exp  = |d.f;
                end
            end
            req_p  = eng_if.test_req;
            done_p = done;
        end
    end

    initial begin
        int h, m, k, ok;
        spi_reset = 1'b1; en = 1'b0; skip_in = '0; dbg_in = '0; cont = 1'b0;
        for (int i = 0; i < N; i++) begin lat[i] = 5; pres[i] = 1; end
        step(3);
        chk("rst_test_req", eng_if.test_req, 1'b0);
        chk("rst_test_ch", 32'(eng_if.test_ch), 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_debug_hold", debug_hold, 1'b0);
        chk("rst_pass_mask", pass_mask, 0);
        chk("rst_fail_mask", fail_mask, 0);
        chk("rst_timeout_mask", timeout_mask, 0);
        chk("rst_any_fail", any_fail, 1'b0);
        spi_reset = 1'b0;
        step(2);

        // All channels tested, all pass after 5 cycles.
        run(16'h0000, 16'h0000);
        // Only ch0 tested and it fails.
        lat[0] = 4; pres[0] = 0;
        run(16'hFFFE, 16'h0000);
        lat[0] = 5; pres[0] = 1;
        // Everything skipped.
        run(16'hFFFF, 16'h0000);
        // ch3 never answers: full timeout window.
        lat[3] = 0;
        run(16'hFFF7, 16'h0000);
        lat[3] = 5;
        // ch2 answers exactly on the terminal cycle.
        lat[2] = TO; pres[2] = 1;
        run(16'hFFFB, 16'h0000);
        lat[2] = 5;

        // Randomized runs.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) begin
                lat[i]  = $urandom_range(1, 12);
                pres[i] = 1'($urandom);
            end
            run(16'($urandom), 16'h0000);
        end

        // Mask inputs changing mid-run must not affect the current run.
        start_run(16'($urandom), 16'h0000, h);
        step(20);
        skip_in = ~skip_m;
        dbg_in  = 16'hFFFF;
        finish_run(9000);
        dbg_in = '0;

        // Debug hold on ch0, with a stray continue before the hold.
        for (int i = 0; i < N; i++) begin lat[i] = 3; pres[i] = 1; end
        start_run(16'hFFFC, 16'h0001, h);
        step(1);
        cont = 1'b1;
        step(1);
        cont = 1'b0;
        k = 0;
        while (cyc < h && k < 100) begin step(1); k++; end
        chk("hold_entry", debug_hold, 1'b1);
        chk("hold_pass_mask", pass_mask, e_pass);
        ok = 1;
        repeat (100) begin
            step(1);
            if (!debug_hold || eng_if.test_req) ok = 0;
        end
        chk("hold_stays", ok, 1);
        m = cyc;
        cont = 1'b1;
        plan(1, m + 1, h);
        step(1);
        cont = 1'b0;
        finish_run(200);

        // Abort mid-WAIT on ch3, then restart.
        for (int i = 0; i < N; i++) begin lat[i] = 2; pres[i] = 1; end
        lat[3] = 0;
        start_run(16'hFFF0, 16'h0000, h);
        k = 0;
        while (!(eng_if.test_req && eng_if.test_ch == 4'd3) && k < 200) begin step(1); k++; end
        chk("abort_reached_ch3", 32'(eng_if.test_ch), 3);
        step(10);
        en = 1'b0;
        step(1);
        chk("abort_test_req", eng_if.test_req, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_pass_mask", pass_mask, 16'h0007);
        chk("abort_fail_mask", fail_mask, 16'h0000);
        chk("abort_timeout_mask", timeout_mask, 16'h0000);
        exp_req_q.delete();
        exp_done_q.delete();
        step(2);
        lat[3] = 2;
        start_run(16'hFFF0, 16'h0000, h);
        step(1);
        chk("restart_busy", busy, 1'b1);
        chk("restart_pass_mask", pass_mask, 16'h0000);
        finish_run(200);

        // Reset pulse mid-run.
        for (int i = 0; i < N; i++) begin lat[i] = 10; pres[i] = 0; end
        start_run(16'h0000, 16'h0000, h);
        step(30);
        spi_reset = 1'b1;
        en = 1'b0;
        step(1);
        chk("mrst_test_req", eng_if.test_req, 1'b0);
        chk("mrst_test_ch", 32'(eng_if.test_ch), 0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_debug_hold", debug_hold, 1'b0);
        chk("mrst_fail_mask", fail_mask, 0);
        chk("mrst_any_fail", any_fail, 1'b0);
        spi_reset = 1'b0;
        exp_req_q.delete();
        exp_done_q.delete();
        step(5);
        chk("mrst_idle_busy", busy, 1'b0);

        chk("req_left_over", exp_req_q.size(), 0);
        chk("done_left_over", exp_done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
